// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 30;
  localparam int ARB_DATA_W = 32;

  // Data returned to the owner when a bus access times out.
  localparam logic [ARB_DATA_W-1:0] TIMEOUT_FILL = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_e;
  typedef enum logic       {OWN_INS, OWN_DAT} arb_owner_e;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: BUSY-cycle watchdog for the arbiter.
// Only present when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_arb_timer #(
  parameter int CYCLES = 255
) (
  input  logic cpu_clk,
  input  logic cpu_rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [CW-1:0] cnt;

  // expire fires during the CYCLES-th enabled cycle so the FSM leaves on that edge
  assign expire = en && (cnt == CW'(CYCLES - 1));

  // count enabled cycles, restart on every grant
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)  cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= cnt + CW'(1);
  end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one hold-until-ack memory port between fetch and data.
// Data has priority; a starvation counter forces a fetch grant after
// STARVE_MAX consecutive data wins. Define MEM_TIMEOUT_EN to abort
// accesses that see no mem_ack within TIMEOUT_CYCLES (sticky mem_err).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ARB_ADDR_W,
  parameter int DATA_W     = ARB_DATA_W,
  parameter int STARVE_MAX = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic                cpu_clk,
  input  logic                cpu_rst_n,
  input  logic                ins_req,
  input  logic [ADDR_W-1:0]   ins_addr,
  output logic                ins_res,
  output logic [DATA_W-1:0]   ins_data,
  input  logic                dat_req,
  input  logic                dat_we,
  input  logic [DATA_W/8-1:0] dat_be,
  input  logic [ADDR_W-1:0]   dat_addr,
  input  logic [DATA_W-1:0]   dat_wdata,
  output logic                dat_res,
  output logic [DATA_W-1:0]   dat_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                mem_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state, state_nxt;
  arb_owner_e    owner;
  logic [SW-1:0] starve_cnt;
  logic          grant, done, pick_ins, expire;
  logic [DATA_W-1:0] rdata_sel;

  // fetch wins when alone, or when it has waited out STARVE_MAX data grants
  assign pick_ins = ins_req && (!dat_req || starve_cnt == SW'(STARVE_MAX));

`ifdef MEM_TIMEOUT_EN
  mem_arb_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
    .cpu_clk   (cpu_clk),
    .cpu_rst_n (cpu_rst_n),
    .clr       (grant),
    .en        (state == BUSY),
    .expire    (expire)
  );

  assign rdata_sel = mem_ack ? mem_rdata : DATA_W'(TIMEOUT_FILL);

  // sticky error on an access that ended by timeout rather than ack
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n)          mem_err <= 1'b0;
    else if (done && !mem_ack) mem_err <= 1'b1;
  end
`else
  assign expire    = 1'b0;
  assign rdata_sel = mem_rdata;
  assign mem_err   = 1'b0;
`endif

  // state register
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) state <= IDLE;
    else            state <= state_nxt;
  end

  // next state and grant/complete strobes; RESP never grants
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (ins_req || dat_req) begin
        grant     = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: if (mem_ack || expire) begin
        done      = 1'b1;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus launch at grant, data capture at completion
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      owner     <= OWN_INS;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ins_data  <= '0;
      dat_rdata <= '0;
    end else if (grant) begin
      mem_req <= 1'b1;
      if (pick_ins) begin
        owner     <= OWN_INS;
        mem_we    <= 1'b0;
        mem_be    <= '1;
        mem_addr  <= ins_addr;
        mem_wdata <= '0;
      end else begin
        owner     <= OWN_DAT;
        mem_we    <= dat_we;
        mem_be    <= dat_we ? dat_be : '1;
        mem_addr  <= dat_addr;
        mem_wdata <= dat_wdata;
      end
    end else if (done) begin
      mem_req <= 1'b0;
      if (owner == OWN_INS) ins_data  <= rdata_sel;
      else if (!mem_we)     dat_rdata <= rdata_sel;
    end
  end

  // consecutive data wins while fetch waits; any fetch win or idle fetch clears
  always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) starve_cnt <= '0;
    else if (grant) begin
      if (pick_ins || !ins_req)            starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX)) starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign ins_res = (state == RESP) && (owner == OWN_INS);
  assign dat_res = (state == RESP) && (owner == OWN_DAT);
  assign busy    = (state != IDLE);

endmodule
